// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
package sram_bist_pkg;

  localparam int unsigned NumElems  = 6;
  localparam int unsigned ElemWidth = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // One march element: address direction plus optional read and write ops.
  // Data values are single bits that expand to an all-zeros/all-ones word.
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_val;
    logic has_write;
    logic write_val;
  } march_elem_t;

  // March C-: {up w0} {up r0 w1} {up r1 w0} {dn r0 w1} {dn r1 w0} {up r0}
  localparam march_elem_t MarchCMinus [NumElems] = '{
    '{dir_down: 1'b0, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0},
    '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1},
    '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0},
    '{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1},
    '{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0},
    '{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0}
  };

  // Table lookup that tolerates out-of-range indices (falls back to the last element).
  function automatic march_elem_t march_elem(input logic [ElemWidth-1:0] idx);
    march_elem_t e;
    e = MarchCMinus[NumElems-1];
    for (int unsigned i = 0; i < NumElems; i++) begin
      if (idx == ElemWidth'(i)) e = MarchCMinus[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/sram_bist_ctrl.sv
// March C- BIST sequencer and port owner for a single-port, 1-cycle-latency SRAM.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned NumWords  = 512,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  input  logic                 func_req_i,
  input  logic                 func_we_i,
  input  logic [AddrWidth-1:0] func_addr_i,
  input  logic [DataWidth-1:0] func_wdata_i,
  input  logic [BeWidth-1:0]   func_be_i,
  output logic                 func_gnt_o,
  output logic [DataWidth-1:0] func_rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [BeWidth-1:0]   mem_be_o,
  input  logic [DataWidth-1:0] mem_rdata_i
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [ElemWidth-1:0] LastElem = ElemWidth'(NumElems - 1);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [ElemWidth-1:0]   elem_q, elem_d;
  logic                   wr_phase_q, wr_phase_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   rd_val_q, rd_val_d;
  logic [AddrWidth-1:0]   rd_addr_q, rd_addr_d;
  logic [ElemWidth-1:0]   rd_elem_q, rd_elem_d;
  logic                   fail_q, fail_d;
  logic [AddrWidth-1:0]   fail_addr_q, fail_addr_d;
  logic [ElemWidth-1:0]   fail_elem_q, fail_elem_d;

  march_elem_t            cur_c;
  logic [ElemWidth-1:0]   elem_nxt_c;
  logic                   nxt_down_c;
  logic                   op_read_c;
  logic                   op_val_c;
  logic                   last_addr_c;
  logic                   mismatch_c;
  logic                   busy_c;

  // Decode the op for this cycle and check the read issued last cycle.
  always_comb begin
    cur_c       = march_elem(elem_q);
    elem_nxt_c  = elem_q + ElemWidth'(1);
    nxt_down_c  = 1'b0;
    for (int unsigned i = 0; i < NumElems; i++) begin
      if (elem_nxt_c == ElemWidth'(i)) nxt_down_c = MarchCMinus[i].dir_down;
    end
    op_read_c   = cur_c.has_read && !wr_phase_q;
    op_val_c    = op_read_c ? cur_c.read_val : cur_c.write_val;
    last_addr_c = cur_c.dir_down ? (addr_q == '0) : (addr_q == LastAddr);
    mismatch_c  = rd_pend_q && (mem_rdata_i != {DataWidth{rd_val_q}});
    busy_c      = (state_q == StRun) || (state_q == StDrain);
  end

  // State and sequencing registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      elem_q      <= '0;
      wr_phase_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_val_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      wr_phase_q  <= wr_phase_d;
      rd_pend_q   <= rd_pend_d;
      rd_val_q    <= rd_val_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  // Next-state: march sequencing, read tracking and first-failure capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    wr_phase_d  = wr_phase_q;
    rd_pend_d   = 1'b0;
    rd_val_d    = rd_val_q;
    rd_addr_d   = rd_addr_q;
    rd_elem_d   = rd_elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;

    if (mismatch_c && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_elem_d = rd_elem_q;
    end

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d     = StRun;
          addr_d      = '0;
          elem_d      = '0;
          wr_phase_d  = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      StRun: begin
        rd_pend_d = op_read_c;
        rd_val_d  = op_val_c;
        rd_addr_d = addr_q;
        rd_elem_d = elem_q;
        if (op_read_c && cur_c.has_write) begin
          wr_phase_d = 1'b1;
        end else begin
          wr_phase_d = 1'b0;
          if (last_addr_c) begin
            if (elem_q == LastElem) begin
              state_d = StDrain;
            end else begin
              elem_d = elem_nxt_c;
              addr_d = nxt_down_c ? LastAddr : '0;
            end
          end else begin
            addr_d = cur_c.dir_down ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Memory port mux: BIST owns the port while busy, otherwise passthrough.
  always_comb begin
    if (busy_c) begin
      mem_req_o   = 1'b1;
      mem_we_o    = !op_read_c;
      mem_addr_o  = addr_q;
      mem_wdata_o = op_read_c ? '0 : {DataWidth{cur_c.write_val}};
      mem_be_o    = '1;
      func_gnt_o  = 1'b0;
    end else begin
      mem_req_o   = func_req_i;
      mem_we_o    = func_we_i;
      mem_addr_o  = func_addr_i;
      mem_wdata_o = func_wdata_i;
      mem_be_o    = func_be_i;
      func_gnt_o  = func_req_i;
    end
  end

  assign func_rdata_o = mem_rdata_i;
  assign busy_o       = busy_c;
  assign done_o       = (state_q == StDone);
  assign fail_o       = fail_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_elem_o  = fail_elem_q;

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
March C- built-in self-test sequencer and port owner for one single-port, 1-cycle-latency tc_sram instance (NumPorts=1, Latency=1).
- Sits between the functional requester and the SRAM.
- On start_i it takes exclusive ownership of the memory port, runs March C-, and reports pass/fail with the first failing address and element.
- When not testing, it passes functional accesses straight through.

Parameters:
NumWords, 512, words in the attached SRAM (>=2)
DataWidth, 32, data width of the attached SRAM
ByteWidth, 8, byte-enable granularity
AddrWidth, $clog2(NumWords), derived, do not override
BeWidth, ceil(DataWidth/ByteWidth), derived, do not override

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start pulse; sampled in IDLE or DONE only
busy_o  in/out: out  1  high in RUN and DRAIN
done_o  out  1  high in DONE until next start or reset
fail_o  out  1  sticky, at least one mismatch since last start
fail_addr_o  out  AddrWidth  address of first mismatch
fail_elem_o  out  3  march element index (0-5) of first mismatch
func_req_i  in  1  functional request
func_we_i  in  1  functional write enable
func_addr_i  in  AddrWidth  functional address
func_wdata_i  in  DataWidth  functional write data
func_be_i  in  BeWidth  functional byte enables
func_gnt_o  out  1  request accepted this cycle
func_rdata_o  out  DataWidth  read data, valid 1 cycle after a granted read
mem_req_o  out  1  SRAM request
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AddrWidth  SRAM address
mem_wdata_o  out  DataWidth  SRAM write data
mem_be_o  out  BeWidth  SRAM byte enables
mem_rdata_i  in  DataWidth  SRAM read data, 1-cycle latency

Behaviour:
- Clocking and reset: clk_i only; rst_ni is asynchronous, active-low.
- Reset values: state=IDLE; busy_o, done_o, fail_o = 0; fail_addr_o, fail_elem_o = 0; all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start_i--> RUN.
  - RUN --last op issued--> DRAIN.
  - DRAIN --1 cycle--> DONE.
- March C- element table (D = DataWidth):
  - E0: up, w0
  - E1: up, r0 w1
  - E2: up, r1 w0
  - E3: down, r0 w1
  - E4: down, r1 w0
  - E5: up, r0
  - "0" = all-zeros word, "1" = all-ones word.
- Addressing: "up" runs 0..NumWords-1; "down" runs NumWords-1..0.
- Element sequencing: for two-op elements, both ops are issued at one address in consecutive cycles (read, then write) before the address advances.
  - On the last address of an element, the next cycle issues the first op of the next element with no bubble.
- Throughput: one op per cycle. Total RUN cycles = 10*NumWords.
- Timing from a start_i sampled at edge t0:
  - ops issue in cycles t1..t10N;
  - DRAIN is cycle t10N+1;
  - done_o is high from cycle t10N+2 (N = NumWords).
- Memory signals while busy: mem_req_o=1, mem_be_o all ones, mem_we_o per op; mem_wdata_o = write value on writes, 0 on reads.
- Read compare:
  - A read issued in cycle k is compared against its expected value in cycle k+1, in parallel with the op issued in k+1. The read in DRAIN is compared the same way.
  - On a mismatch with fail_o still 0: capture fail_addr_o/fail_elem_o and set fail_o. Later mismatches do not update the capture.
  - The test always runs to completion.
- New start: start_i in DONE clears fail_o, fail_addr_o, fail_elem_o and done_o on entry to RUN.
- start_i while busy is ignored.
- Functional port:
  - IDLE/DONE: combinational passthrough (mem_* = func_*), func_gnt_o = func_req_i.
  - RUN/DRAIN: func_gnt_o = 0; the requester holds its request.
  - func_rdata_o = mem_rdata_i always.
- Reset mid-run: immediate return to IDLE, mem_req_o follows func_req_i, results cleared. No partial results are retained.
- Power-of-two NumWords is not required: address counters compare against NumWords-1 explicitly.

Decomposition:
- Package sram_bist_pkg:
  - state_e enum;
  - march_elem_t struct {dir_down, has_read, read_val, has_write, write_val};
  - localparam array MarchCMinus[6];
  - NumElems=6.
- Single module; no sub-module is needed. Address/element counters and compare logic stay local.

Test Plan:
1. NumWords=4, fault-free memory model, start_i at t0:
   - mem ops trace E0 w0@0..3, then E1 r0@0 w1@0 r0@1 ...;
   - done_o rises at t42;
   - fail_o=0.
2. Stuck-at-0 on bit 3 at address 2:
   - done_o at t42, fail_o=1, fail_addr_o=2, fail_elem_o=2.
3. Address-decoder alias (every write to address 3 also writes address 1), NumWords=4:
   - fail_o=1, fail_addr_o=1, fail_elem_o=3.
4. Functional access:
   - In IDLE, func write 0xDEADBEEF to addr 5 and read it back: func_gnt_o=1 same cycle; func_rdata_o=0xDEADBEEF one cycle after the read.
   - During RUN, func_req_i=1: func_gnt_o=0, no functional access reaches mem_*.
5. Second start_i pulse mid-RUN is ignored: done_o still at t42. Then start_i in DONE after a failing run: fail_o clears, and a clean run ends with fail_o=0.
6. rst_ni asserted at cycle t20 of a run:
   - same cycle: busy_o=0, done_o=0, fail_o=0, mem_req_o=func_req_i;
   - a subsequent start_i gives a full 10N+2 run.
